// File: rtl/dht_pkg.sv
// Shared DHT11 definitions: bus timing in microseconds (1 tick = 1 us at 1 MHz),
// the responder state encoding and the 40-bit frame field layout.
// Also used by the DHT11 reader, so keep names stable.
package dht_pkg;

    localparam int DHT_START_MIN_US = 18000;
    localparam int DHT_RESP_DLY_US  = 30;
    localparam int DHT_RESP_LOW_US  = 80;
    localparam int DHT_RESP_HIGH_US = 80;
    localparam int DHT_BIT_LOW_US   = 50;
    localparam int DHT_BIT0_HIGH_US = 26;
    localparam int DHT_BIT1_HIGH_US = 70;
    localparam int DHT_EOT_LOW_US   = 50;
    localparam int DHT_CNT_W        = 15;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_REL  = 3'd1,
        RESP_LOW  = 3'd2,
        RESP_HIGH = 3'd3,
        BIT_LOW   = 3'd4,
        BIT_HIGH  = 3'd5,
        EOT       = 3'd6
    } dht_state_t;

    // Frame layout, sent MSB (bit 39) first.
    localparam int FRAME_W        = 40;
    localparam int LAST_BIT       = FRAME_W - 1;
    localparam int HUM_INT_LSB    = 32;
    localparam int HUM_FLOAT_LSB  = 24;
    localparam int TEMP_INT_LSB   = 16;
    localparam int TEMP_FLOAT_LSB = 8;
    localparam int CSUM_LSB       = 0;

    // Byte sum mod 256; corrupt flips bit 0 for error injection.
    function automatic logic [7:0] dht_csum(input logic [7:0] a, input logic [7:0] b,
                                            input logic [7:0] c, input logic [7:0] d,
                                            input logic corrupt);
        logic [7:0] s;
        s = a + b + c + d;
        return s ^ {7'b0, corrupt};
    endfunction

    function automatic logic [FRAME_W-1:0] dht_frame(input logic [7:0] hi, input logic [7:0] hf,
                                                     input logic [7:0] ti, input logic [7:0] tf,
                                                     input logic corrupt);
        logic [FRAME_W-1:0] f;
        f = '0;
        f[HUM_INT_LSB    +: 8] = hi;
        f[HUM_FLOAT_LSB  +: 8] = hf;
        f[TEMP_INT_LSB   +: 8] = ti;
        f[TEMP_FLOAT_LSB +: 8] = tf;
        f[CSUM_LSB       +: 8] = dht_csum(hi, hf, ti, tf, corrupt);
        return f;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous level.
// Ports: clk, rst_n (sync, active low), d (async input), q (synchronized output).
// RESET_VAL sets the output during reset; for an open-drain bus that is the idle-high level.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/dht_sensor_emu.sv
// DHT11 sensor-side responder. Waits for a host start pulse (long low, then release),
// answers with the 80/80 us preamble and a 40-bit frame
// {hum_int, hum_float, temp_int, temp_float, checksum}, MSB first.
// The block only ever pulls the bus low; the board pull-up provides the high level.
// Ports:
//   clk          1 MHz clock, one tick per microsecond
//   rst_n        synchronous reset, active low
//   data_in      bus level from the pad (asynchronous)
//   drive_low    1 = pull the bus low
//   enable       respond to start pulses (looked at only in IDLE)
//   hum_int, hum_float, temp_int, temp_float   payload bytes, latched at start detection
//   corrupt_csum invert checksum bit 0 for the latched frame
//   busy         start detection until bus release
//   frame_done   one-cycle pulse when the final low slot ends
//   fsm_state    current FSM state (debug visibility)
module dht_sensor_emu
    import dht_pkg::*;
#(
    parameter int START_MIN_US = DHT_START_MIN_US,
    parameter int RESP_DLY_US  = DHT_RESP_DLY_US,
    parameter int RESP_LOW_US  = DHT_RESP_LOW_US,
    parameter int RESP_HIGH_US = DHT_RESP_HIGH_US,
    parameter int BIT_LOW_US   = DHT_BIT_LOW_US,
    parameter int BIT0_HIGH_US = DHT_BIT0_HIGH_US,
    parameter int BIT1_HIGH_US = DHT_BIT1_HIGH_US,
    parameter int EOT_LOW_US   = DHT_EOT_LOW_US,
    parameter int CNT_W        = DHT_CNT_W
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       data_in,
    output logic       drive_low,
    input  logic       enable,
    input  logic [7:0] hum_int,
    input  logic [7:0] hum_float,
    input  logic [7:0] temp_int,
    input  logic [7:0] temp_float,
    input  logic       corrupt_csum,
    output logic       busy,
    output logic       frame_done,
    output logic [2:0] fsm_state
);

    localparam logic [CNT_W-1:0] TIMER_MAX = '1;
    localparam logic [CNT_W-1:0] START_MIN = CNT_W'(START_MIN_US);

    logic               data_s;
    dht_state_t         state;
    logic [CNT_W-1:0]   timer;
    logic [5:0]         bit_idx;
    logic [FRAME_W-1:0] frame;
    logic               cur_bit;
    logic [CNT_W-1:0]   last_tick;

    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (data_in),
        .q     (data_s)
    );

    assign fsm_state = state;

    always_comb begin
        cur_bit = frame[6'(LAST_BIT) - bit_idx];
    end

    // Final timer value of the current state: each state lasts exactly N ticks.
    always_comb begin
        last_tick = '0;
        case (state)
            WAIT_REL:  last_tick = CNT_W'(RESP_DLY_US - 1);
            RESP_LOW:  last_tick = CNT_W'(RESP_LOW_US - 1);
            RESP_HIGH: last_tick = CNT_W'(RESP_HIGH_US - 1);
            BIT_LOW:   last_tick = CNT_W'(BIT_LOW_US - 1);
            BIT_HIGH:  last_tick = cur_bit ? CNT_W'(BIT1_HIGH_US - 1) : CNT_W'(BIT0_HIGH_US - 1);
            EOT:       last_tick = CNT_W'(EOT_LOW_US - 1);
            default:   last_tick = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            timer      <= '0;
            bit_idx    <= '0;
            frame      <= '0;
            drive_low  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (state == IDLE) begin
                drive_low <= 1'b0;
                if (data_s) begin
                    timer <= '0;
                    // The timer is cleared every high cycle, so a nonzero value here
                    // means the previous cycle was low: this is the 0->1 edge.
                    if (enable && (timer >= START_MIN)) begin
                        frame <= dht_frame(hum_int, hum_float, temp_int, temp_float,
                                           corrupt_csum);
                        busy  <= 1'b1;
                        state <= WAIT_REL;
                    end
                end else if (timer != TIMER_MAX) begin
                    timer <= timer + 1'b1;
                end
            end else if (timer != last_tick) begin
                timer <= timer + 1'b1;
            end else begin
                timer <= '0;
                case (state)
                    WAIT_REL: begin
                        drive_low <= 1'b1;
                        state     <= RESP_LOW;
                    end
                    RESP_LOW: begin
                        drive_low <= 1'b0;
                        state     <= RESP_HIGH;
                    end
                    RESP_HIGH: begin
                        drive_low <= 1'b1;
                        bit_idx   <= '0;
                        state     <= BIT_LOW;
                    end
                    BIT_LOW: begin
                        drive_low <= 1'b0;
                        state     <= BIT_HIGH;
                    end
                    BIT_HIGH: begin
                        drive_low <= 1'b1;
                        if (bit_idx == 6'(LAST_BIT)) begin
                            state <= EOT;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            state   <= BIT_LOW;
                        end
                    end
                    EOT: begin
                        drive_low  <= 1'b0;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                        state      <= IDLE;
                    end
                    default: begin
                        drive_low <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dht_sensor_emu.sv
// Bench for dht_sensor_emu. The start threshold is scaled down to 400 us so the run
// stays short; every other timing uses the default values. The bus is modelled as an
// open-drain wire: low if the host or the DUT pulls it.
`timescale 1ns/1ps
module tb_dht_sensor_emu;
    import dht_pkg::*;

    localparam int START_MIN = 400;
    localparam int NVEC      = 8;

    logic       clk;
    logic       rst_n;
    logic       host_low;
    logic       data_in;
    logic       drive_low;
    logic       enable;
    logic [7:0] hum_int, hum_float, temp_int, temp_float;
    logic       corrupt_csum;
    logic       busy;
    logic       frame_done;
    logic [2:0] fsm_state;

    int checks;
    int errors;
    int done_cnt;

    assign data_in = ~(host_low | drive_low);

    dht_sensor_emu #(.START_MIN_US(START_MIN)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_in      (data_in),
        .drive_low    (drive_low),
        .enable       (enable),
        .hum_int      (hum_int),
        .hum_float    (hum_float),
        .temp_int     (temp_int),
        .temp_float   (temp_float),
        .corrupt_csum (corrupt_csum),
        .busy         (busy),
        .frame_done   (frame_done),
        .fsm_state    (fsm_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done) done_cnt++;
    end

    initial begin
        #(1_000_000);
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0]  hi, hf, ti, tf;
        logic        corrupt;
        logic        en;
        int          low_len;
        logic        glitch;
        logic        resp;
        logic [39:0] exp_frame;
    } vec_t;

    vec_t vecs[NVEC];

    function automatic vec_t mk(input logic [7:0] hi, input logic [7:0] hf, input logic [7:0] ti,
                                input logic [7:0] tf, input logic corrupt, input logic en,
                                input int low_len, input logic glitch, input logic resp,
                                input logic [39:0] exp_frame);
        vec_t v;
        v.hi = hi; v.hf = hf; v.ti = ti; v.tf = tf;
        v.corrupt = corrupt; v.en = en; v.low_len = low_len; v.glitch = glitch;
        v.resp = resp; v.exp_frame = exp_frame;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drives one host start pulse and checks the response waveform slot by slot.
    task automatic run_vec(input vec_t t, input string tag);
        int          runs[100];
        int          nruns;
        int          len;
        int          lat;
        int          cyc;
        int          exp_len;
        int          act_len;
        int          bad;
        int          done0;
        logic        cur;
        logic [39:0] decoded;
        @(negedge clk);
        hum_int = t.hi; hum_float = t.hf; temp_int = t.ti; temp_float = t.tf;
        corrupt_csum = t.corrupt; enable = t.en;
        host_low = 1'b1;
        repeat (t.low_len) @(negedge clk);
        host_low = 1'b0;
        done0 = done_cnt;

        if (!t.resp) begin
            bad = 0;
            repeat (200) begin
                @(posedge clk); #1;
                if (drive_low || busy) bad++;
            end
            check({tag, " no_response_activity"}, 64'(bad), 64'd0);
            check({tag, " no_response_done"}, 64'(done_cnt - done0), 64'd0);
            return;
        end

        // 2 sync flops plus the registered detection.
        lat = 0;
        while (!busy && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " busy_latency"}, 64'(lat), 64'd3);

        // Later input changes must not affect the latched frame.
        hum_int = ~t.hi; hum_float = ~t.hf; temp_int = ~t.ti; temp_float = ~t.tf;
        corrupt_csum = ~t.corrupt;

        nruns = 0;
        cur = drive_low;
        len = 1;
        cyc = 0;
        while (cyc < 8000) begin
            @(posedge clk); #1;
            cyc++;
            if (t.glitch) begin
                if (cyc == 1000) host_low = 1'b1;
                if (cyc == 1100) host_low = 1'b0;
            end
            if (!busy) break;
            if (drive_low == cur) begin
                len++;
            end else begin
                if (nruns < 100) runs[nruns] = len;
                nruns++;
                cur = drive_low;
                len = 1;
            end
        end
        host_low = 1'b0;
        if (nruns < 100) runs[nruns] = len;
        nruns++;
        check({tag, " release_in_time"}, 64'(cyc < 8000), 64'd1);
        check({tag, " done_at_release"}, 64'(frame_done), 64'd1);
        check({tag, " bus_released"}, 64'(drive_low), 64'd0);
        check({tag, " slot_count"}, 64'(nruns), 64'd84);

        // Slot sequence: 30 released, 80 low, 80 high, 40 x (50 low, 26/70 high), 50 low.
        decoded = '0;
        bad = 0;
        for (int k = 0; k < 84 && k < nruns; k++) begin
            if (k == 0)                 exp_len = 30;
            else if (k == 1 || k == 2)  exp_len = 80;
            else if (k == 83)           exp_len = 50;
            else if ((k - 3) % 2 == 0)  exp_len = 50;
            else                        exp_len = t.exp_frame[39 - (k - 4) / 2] ? 70 : 26;
            act_len = runs[k];
            if (act_len != exp_len) begin
                bad++;
                check($sformatf("%s slot%0d_len", tag, k), 64'(act_len), 64'(exp_len));
            end
            if (k >= 4 && k <= 82 && (k - 4) % 2 == 0) decoded[39 - (k - 4) / 2] = (act_len > 48);
        end
        check({tag, " slot_timing_errors"}, 64'(bad), 64'd0);
        check({tag, " frame"}, 64'(decoded), 64'(t.exp_frame));

        @(posedge clk); #1;
        check({tag, " done_one_cycle"}, 64'(frame_done), 64'd0);
        check({tag, " done_count"}, 64'(done_cnt - done0), 64'd1);
        check({tag, " state_idle"}, 64'(fsm_state), 64'(IDLE));
    endtask

    initial begin
        int rises;
        int cyc;
        logic prev;
        checks = 0; errors = 0; done_cnt = 0;
        rst_n = 1'b0; host_low = 1'b0; enable = 1'b0;
        hum_int = '0; hum_float = '0; temp_int = '0; temp_float = '0; corrupt_csum = 1'b0;

        //                hi     hf     ti     tf    cor   en   low       gl    resp  frame
        vecs[0] = mk(8'h37, 8'h00, 8'h19, 8'h05, 1'b0, 1'b1, 500,      1'b0, 1'b1, 40'h3700190555);
        vecs[1] = mk(8'h37, 8'h00, 8'h19, 8'h05, 1'b1, 1'b1, 500,      1'b0, 1'b1, 40'h3700190554);
        vecs[2] = mk(8'h37, 8'h00, 8'h19, 8'h05, 1'b0, 1'b1, 250,      1'b0, 1'b0, 40'h0);
        vecs[3] = mk(8'h41, 8'h00, 8'h1E, 8'h00, 1'b0, 1'b1, 500,      1'b1, 1'b1, 40'h41001E005F);
        vecs[4] = mk(8'h37, 8'h00, 8'h19, 8'h05, 1'b0, 1'b1, START_MIN - 1, 1'b0, 1'b0, 40'h0);
        vecs[5] = mk(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b1, START_MIN, 1'b0, 1'b1, 40'hFFFFFFFFFC);
        vecs[6] = mk(8'h37, 8'h00, 8'h19, 8'h05, 1'b0, 1'b0, 500,      1'b0, 1'b0, 40'h0);
        vecs[7] = mk(8'hAA, 8'h55, 8'h00, 8'h01, 1'b1, 1'b1, 500,      1'b0, 1'b1, 40'hAA55000101);

        repeat (3) @(negedge clk);
        check("reset drive_low", 64'(drive_low), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset frame_done", 64'(frame_done), 64'd0);
        check("reset state", 64'(fsm_state), 64'(IDLE));
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        for (int i = 0; i < NVEC; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
            repeat (20) @(negedge clk);
        end

        // Reset during the bit-12 low slot abandons the frame immediately.
        @(negedge clk);
        hum_int = 8'h37; hum_float = 8'h00; temp_int = 8'h19; temp_float = 8'h05;
        corrupt_csum = 1'b0; enable = 1'b1;
        host_low = 1'b1;
        repeat (500) @(negedge clk);
        host_low = 1'b0;
        rises = 0;
        cyc = 0;
        prev = 1'b0;
        // Rise 1 starts the preamble low, rise k+2 starts bit k's low slot.
        while (rises < 14 && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
            if (drive_low && !prev) rises++;
            prev = drive_low;
        end
        check("midreset reached_bit12", 64'(rises), 64'd14);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midreset drive_low", 64'(drive_low), 64'd0);
        check("midreset busy", 64'(busy), 64'd0);
        check("midreset state", 64'(fsm_state), 64'(IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        repeat (100) begin
            @(posedge clk); #1;
            if (drive_low || busy) cyc++;
        end
        check("midreset stays_idle", 64'(cyc), 64'd0);
        run_vec(vecs[0], "after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
